serializer_tx: RTL and testbench

SERIALIZER_TX -- requirements
Module: serializer_tx

---
 rtl/serializer_tx.sv | 118 +++++++++++
 tb/tb_serializer_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: captures one WIDTH-bit word, shifts it out on sout.
// Latency: first bit on sout the cycle after acceptance; one bit per tx_en-high cycle.
// Backpressure: in_ready is high only in IDLE; tx_en low stalls the shift indefinitely.
module serializer_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             tx_en,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_sout;
  logic             w_accept;
  logic             w_last;
  logic             w_first;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  assign w_last     = (r_cnt == LAST);
  assign w_accept   = in_valid && in_ready;
  // Bit selection: the shift register always holds the just-presented bit at the
  // "outgoing" end, so the next bit is the neighbour one position inward.
  assign w_first    = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign w_next_bit = MSB_FIRST ? r_shreg[WIDTH-2] : r_shreg[1];
  assign w_shifted  = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shreg[WIDTH-1:1]};
  assign sout       = r_sout;

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake/status outputs; in_ready is masked while reset is held.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (tx_en && w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, advance one bit per enabled SHIFT cycle, clear on the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= in_data;
            r_cnt   <= '0;
            r_sout  <= w_first;
          end
        end
        SHIFT: begin
          if (tx_en) begin
            if (w_last) begin
              r_shreg <= '0;
              r_cnt   <= '0;
              r_sout  <= 1'b0;
            end else begin
              r_shreg <= w_shifted;
              r_cnt   <= r_cnt + CW'(1);
              r_sout  <= w_next_bit;
            end
          end
        end
        default: begin
          r_sout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_tx.sv
// Testbench for serializer_tx: MSB-first and LSB-first instances share stimulus.
// Table of words with tx_en patterns, plus hand sequences for reset/abort/backpressure.
// Outputs sampled 1 time unit after each rising edge.
module tb_serializer_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       tx_en;
  logic       in_ready_m, sout_m, busy_m, done_m;
  logic       in_ready_l, sout_l, busy_l, done_l;

  int total = 0;
  int bad   = 0;

  serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_m), .tx_en(tx_en), .sout(sout_m), .busy(busy_m), .done(done_m)
  );

  serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_l), .tx_en(tx_en), .sout(sout_l), .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         mode;      // 0: tx_en=1, 1: toggle, 2: random, 3: 20-cycle stall then 1
    int         done_cyc;  // cycle after acceptance carrying done, -1 = don't check
    int         ones;      // ones seen on sout (MSB instance) on tx_en-high cycles
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_in_ready_m"}, in_ready_m, 1);
    chk({nm, "_in_ready_l"}, in_ready_l, 1);
    chk({nm, "_busy_m"}, busy_m, 0);
    chk({nm, "_done_m"}, done_m, 0);
    chk({nm, "_sout_m"}, sout_m, 0);
    chk({nm, "_sout_l"}, sout_l, 0);
  endtask

  function automatic logic pat(input int mode, input int j);
    case (mode)
      0:       return 1'b1;
      1:       return (j % 2) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return j > 20;
    endcase
  endfunction

  // Runs from the first cycle after acceptance through DONE and back to IDLE.
  task automatic run(input logic [7:0] d, input int mode, input int exp_done, input int exp_ones);
    int   idx;
    int   j;
    int   ones;
    logic te;
    idx  = 0;
    j    = 1;
    ones = 0;
    while (idx < 8 && j < 200) begin
      chk("busy_m", busy_m, 1);
      chk("busy_l", busy_l, 1);
      chk("in_ready_shift", in_ready_m, 0);
      chk("done_shift", done_m, 0);
      chk("sout_msb", sout_m, d[7-idx]);
      chk("sout_lsb", sout_l, d[idx]);
      te    = pat(mode, j);
      tx_en = te;
      if (te) ones += int'(sout_m);
      tick();
      if (te) idx++;
      j++;
    end
    if (idx < 8) chk("shift_timeout", idx, 8);
    chk("done_m", done_m, 1);
    chk("done_l", done_l, 1);
    chk("busy_done", busy_m, 0);
    chk("sout_done", sout_m, 0);
    chk("in_ready_done", in_ready_m, 0);
    if (exp_done >= 0) chk("done_cycle", j, exp_done);
    chk("ones_count", ones, exp_ones);
    tx_en = 1'($urandom_range(0, 1));
    tick();
    chk_idle("post");
    chk("done_one_cycle", done_l, 0);
  endtask

  task automatic xfer(input logic [7:0] d, input int mode, input int exp_done, input int exp_ones);
    chk_idle("pre");
    in_valid = 1'b1;
    in_data  = d;
    tx_en    = pat(mode, 0);
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    run(d, mode, exp_done, exp_ones);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 0, 9, 4};
    vecs[1] = '{8'h01, 0, 9, 1};
    vecs[2] = '{8'hFF, 1, 17, 8};
    vecs[3] = '{8'h00, 0, 9, 0};
    vecs[4] = '{8'h3C, 2, -1, 4};
    vecs[5] = '{8'h96, 1, 17, 4};
    vecs[6] = '{8'h5A, 3, 29, 4};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; tx_en = 1'b0;
    #1;
    chk("rst_in_ready", in_ready_m, 0);
    chk("rst_sout", sout_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    tick(); tick();
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready_held", in_ready_m, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready_m", in_ready_m, 1);
    chk("post_rst_in_ready_l", in_ready_l, 1);
    tick();

    // Table-driven words
    for (int i = 0; i < 7; i++) begin
      xfer(vecs[i].data, vecs[i].mode, vecs[i].done_cyc, vecs[i].ones);
    end

    // New word held on in_valid during a transfer is only taken in the next IDLE
    chk_idle("hold_pre");
    in_valid = 1'b1; in_data = 8'hC3; tx_en = 1'b1;
    tick();
    in_data = 8'h3C;
    run(8'hC3, 0, 9, 4);
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    run(8'h3C, 0, 9, 4);

    // Reset mid-word aborts without a done pulse
    in_valid = 1'b1; in_data = 8'hF0; tx_en = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("abort_bit3", sout_m, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_sout", sout_m, 0);
    chk("abort_busy", busy_m, 0);
    chk("abort_done", done_m, 0);
    chk("abort_in_ready", in_ready_m, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("abort_no_done", done_m, 0);
      chk("abort_no_sout", sout_m, 0);
      chk("abort_no_busy", busy_m, 0);
      tick();
    end
    xfer(8'h81, 0, 9, 2);

    // tx_en with no input keeps the block idle
    in_valid = 1'b0; tx_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_idle("idle_txen");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
